// File: rtl/adder_rr_arbiter_if.sv
// Bundle between the requesters, the round-robin adder arbiter and the shared adder.
// The master drives requests and adder results; the arbiter (slave) drives the adder operands and grants.
interface adder_rr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] op_a;
    logic [NREQ*WIDTH-1:0] op_b;
    logic [NREQ-1:0]       op_cin;
    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_b;
    logic                  add_cin;
    logic [WIDTH-1:0]      add_sum;
    logic                  add_carry;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      result;
    logic                  result_carry;
    logic                  busy;

    modport master (
        output req, op_a, op_b, op_cin, add_sum, add_carry,
        input  add_a, add_b, add_cin, grant, done, result, result_carry, busy
    );

    modport slave (
        input  req, op_a, op_b, op_cin, add_sum, add_carry,
        output add_a, add_b, add_cin, grant, done, result, result_carry, busy
    );
endinterface

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter that time-shares one registered adder between NREQ requesters,
// latching the winner's operands and returning the adder result with a one-cycle done pulse.
module adder_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int LAT   = 1
) (
    input  logic              clock,
    input  logic              reset,
    adder_rr_arbiter_if.slave bus
);
    localparam int IDXW = $clog2(NREQ);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDXW-1:0]   r_idx;
    logic [IDXW-1:0]   r_ptr;
    logic [2:0]        r_cnt;
    logic [WIDTH-1:0]  r_add_a;
    logic [WIDTH-1:0]  r_add_b;
    logic              r_add_cin;
    logic [WIDTH-1:0]  r_result;
    logic              r_result_carry;
    logic [NREQ-1:0]   r_grant;
    logic [NREQ-1:0]   r_done;

    logic              w_sel_vld;
    logic [IDXW-1:0]   w_sel_idx;
    logic [NREQ-1:0]   w_sel_oh;
    logic [NREQ-1:0]   w_idx_oh;
    logic [WIDTH-1:0]  w_sel_a;
    logic [WIDTH-1:0]  w_sel_b;
    logic              w_sel_cin;
    logic [IDXW-1:0]   w_ptr_nxt;

    // Two passes: first requests at or above ptr, then wrap to the lowest index.
    always_comb begin
        w_sel_vld = 1'b0;
        w_sel_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_sel_vld && bus.req[i] && (IDXW'(i) >= r_ptr)) begin
                w_sel_vld = 1'b1;
                w_sel_idx = IDXW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_sel_vld && bus.req[i]) begin
                w_sel_vld = 1'b1;
                w_sel_idx = IDXW'(i);
            end
        end
    end

    always_comb begin
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_cin = 1'b0;
        w_sel_oh  = '0;
        w_idx_oh  = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_sel_oh[i] = (w_sel_idx == IDXW'(i));
            w_idx_oh[i] = (r_idx == IDXW'(i));
            if (w_sel_idx == IDXW'(i)) begin
                w_sel_a   = bus.op_a[i*WIDTH +: WIDTH];
                w_sel_b   = bus.op_b[i*WIDTH +: WIDTH];
                w_sel_cin = bus.op_cin[i];
            end
        end
    end

    assign w_ptr_nxt = (r_idx == IDXW'(NREQ - 1)) ? '0 : r_idx + IDXW'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_sel_vld) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == 3'd0) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_idx          <= '0;
            r_ptr          <= '0;
            r_cnt          <= '0;
            r_add_a        <= '0;
            r_add_b        <= '0;
            r_add_cin      <= 1'b0;
            r_result       <= '0;
            r_result_carry <= 1'b0;
            r_grant        <= '0;
            r_done         <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_sel_vld) begin
                        r_idx     <= w_sel_idx;
                        r_add_a   <= w_sel_a;
                        r_add_b   <= w_sel_b;
                        r_add_cin <= w_sel_cin;
                        r_grant   <= w_sel_oh;
                        r_cnt     <= 3'(LAT - 1);
                    end
                end
                S_RUN: begin
                    if (r_cnt != 3'd0) begin
                        r_cnt <= r_cnt - 3'd1;
                    end else begin
                        r_result       <= bus.add_sum;
                        r_result_carry <= bus.add_carry;
                        r_done         <= w_idx_oh;
                    end
                end
                S_DONE: begin
                    r_done  <= '0;
                    r_grant <= '0;
                    r_ptr   <= w_ptr_nxt;
                end
                default: begin
                    r_done  <= '0;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign bus.add_a        = r_add_a;
    assign bus.add_b        = r_add_b;
    assign bus.add_cin      = r_add_cin;
    assign bus.grant        = r_grant;
    assign bus.done         = r_done;
    assign bus.result       = r_result;
    assign bus.result_carry = r_result_carry;
    assign bus.busy         = (r_state != S_IDLE);
endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed bench for adder_rr_arbiter: one LAT=1 and one LAT=4 instance, each with an adder model
// whose first pipeline stage is the arbiter's own add_* register.
module tb_adder_rr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    adder_rr_arbiter_if #(.NREQ(4), .WIDTH(32)) if1 ();
    adder_rr_arbiter_if #(.NREQ(4), .WIDTH(32)) if2 ();

    adder_rr_arbiter #(.NREQ(4), .WIDTH(32), .LAT(1)) dut1 (.clock(clk), .reset(rst), .bus(if1));
    adder_rr_arbiter #(.NREQ(4), .WIDTH(32), .LAT(4)) dut2 (.clock(clk), .reset(rst), .bus(if2));

    // LAT=1: add_* register is the only stage, so the sum is combinational from it.
    logic [32:0] sum1;
    assign sum1          = {1'b0, if1.add_a} + {1'b0, if1.add_b} + {32'd0, if1.add_cin};
    assign if1.add_sum   = sum1[31:0];
    assign if1.add_carry = sum1[32];

    // LAT=4: add_* register plus three more stages.
    logic [32:0] sum2;
    logic [32:0] pipe2 [0:2];
    assign sum2 = {1'b0, if2.add_a} + {1'b0, if2.add_b} + {32'd0, if2.add_cin};
    always @(posedge clk) begin
        pipe2[0] <= sum2;
        pipe2[1] <= pipe2[0];
        pipe2[2] <= pipe2[1];
    end
    assign if2.add_sum   = pipe2[2][31:0];
    assign if2.add_carry = pipe2[2][32];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [31:0] exp_res [0:4];
    logic        exp_cy  [0:4];
    logic [3:0]  oh;

    initial begin
        exp_res[0] = 32'd1100;       exp_cy[0] = 1'b0;
        exp_res[1] = 32'd13101;      exp_cy[1] = 1'b0;
        exp_res[2] = 32'h0000_0000;  exp_cy[2] = 1'b1;
        exp_res[3] = 32'hFFFF_FFFF;  exp_cy[3] = 1'b1;
        exp_res[4] = 32'd1100;       exp_cy[4] = 1'b0;

        if1.req = 4'b1111; if1.op_a = '0; if1.op_b = '0; if1.op_cin = '0;
        if2.req = 4'b1111; if2.op_a = '0; if2.op_b = '0; if2.op_cin = '0;

        // Reset held two cycles with all requests pending
        tick;
        chk("rst_grant",  {60'd0, if1.grant}, 64'd0);
        chk("rst_done",   {60'd0, if1.done}, 64'd0);
        chk("rst_busy",   {63'd0, if1.busy}, 64'd0);
        chk("rst_result", {31'd0, if1.result_carry, if1.result}, 64'd0);
        chk("rst_add",    {31'd0, if1.add_cin, if1.add_a}, 64'd0);
        chk("rst_add_b",  {32'd0, if1.add_b}, 64'd0);
        tick;
        chk("rst_grant2", {60'd0, if1.grant}, 64'd0);
        chk("rst_grant2b", {60'd0, if2.grant}, 64'd0);
        rst = 1'b0; if1.req = 4'b0000; if2.req = 4'b0000;
        tick;
        chk("idle_busy", {63'd0, if1.busy}, 64'd0);

        // Single request on requester 0, LAT=1
        if1.op_a[0 +: 32] = 32'd500; if1.op_b[0 +: 32] = 32'd600; if1.op_cin[0] = 1'b0;
        if1.req = 4'b0001;
        tick;
        chk("single_grant", {60'd0, if1.grant}, 64'h1);
        chk("single_busy",  {63'd0, if1.busy}, 64'd1);
        chk("single_add_a", {32'd0, if1.add_a}, 64'd500);
        chk("single_done0", {60'd0, if1.done}, 64'd0);
        tick;
        chk("single_done",   {60'd0, if1.done}, 64'h1);
        chk("single_result", {32'd0, if1.result}, 64'd1100);
        chk("single_carry",  {63'd0, if1.result_carry}, 64'd0);
        if1.req = 4'b0000;
        tick;
        chk("single_busy_lo",  {63'd0, if1.busy}, 64'd0);
        chk("single_grant_lo", {60'd0, if1.grant}, 64'd0);
        chk("single_done_lo",  {60'd0, if1.done}, 64'd0);
        chk("single_hold",     {32'd0, if1.result}, 64'd1100);

        // Rotation and wrap-around: reset clears the pointer, then all four requesters held high
        rst = 1'b1;
        tick;
        rst = 1'b0;
        if1.op_a[32 +: 32] = 32'd1500;       if1.op_b[32 +: 32] = 32'd11600;      if1.op_cin[1] = 1'b1;
        if1.op_a[64 +: 32] = 32'hFFFF_FFFF;  if1.op_b[64 +: 32] = 32'd1;          if1.op_cin[2] = 1'b0;
        if1.op_a[96 +: 32] = 32'hFFFF_FFFF;  if1.op_b[96 +: 32] = 32'hFFFF_FFFF;  if1.op_cin[3] = 1'b1;
        if1.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % 4);
            tick;
            chk("rot_grant", {60'd0, if1.grant}, {60'd0, oh});
            tick;
            chk("rot_done",   {60'd0, if1.done}, {60'd0, oh});
            chk("rot_result", {32'd0, if1.result}, {32'd0, exp_res[k]});
            chk("rot_carry",  {63'd0, if1.result_carry}, {63'd0, exp_cy[k]});
            if (k == 4) if1.req = 4'b0000;
            tick;
            chk("rot_idle", {59'd0, if1.busy, if1.grant}, 64'd0);
        end

        // Operand change after issue, LAT=4, requester 2
        if2.op_a[64 +: 32] = 32'd50000; if2.op_b[64 +: 32] = 32'd60020; if2.op_cin[2] = 1'b0;
        if2.req = 4'b0100;
        tick;
        chk("opchg_grant", {60'd0, if2.grant}, 64'h4);
        chk("opchg_add_a", {32'd0, if2.add_a}, 64'd50000);
        if2.op_a[64 +: 32] = 32'd0;
        tick;
        chk("opchg_wait1", {60'd0, if2.done}, 64'd0);
        tick;
        chk("opchg_wait2", {60'd0, if2.done}, 64'd0);
        tick;
        chk("opchg_wait3", {59'd0, if2.busy, if2.done}, 64'h10);
        tick;
        chk("opchg_done",   {60'd0, if2.done}, 64'h4);
        chk("opchg_result", {32'd0, if2.result}, 64'd110020);
        chk("opchg_carry",  {63'd0, if2.result_carry}, 64'd0);
        if2.req = 4'b0000;
        tick;
        chk("opchg_idle", {59'd0, if2.busy, if2.grant}, 64'd0);

        // Reset two cycles into RUN aborts the operation
        if2.op_a[32 +: 32] = 32'd7; if2.op_b[32 +: 32] = 32'd8; if2.op_cin[1] = 1'b0;
        if2.req = 4'b0010;
        tick;
        chk("abort_grant", {60'd0, if2.grant}, 64'h2);
        tick;
        tick;
        chk("abort_done_pre", {60'd0, if2.done}, 64'd0);
        rst = 1'b1; if2.req = 4'b0000;
        tick;
        chk("abort_done",   {60'd0, if2.done}, 64'd0);
        chk("abort_grant0", {60'd0, if2.grant}, 64'd0);
        chk("abort_busy",   {63'd0, if2.busy}, 64'd0);
        chk("abort_result", {31'd0, if2.result_carry, if2.result}, 64'd0);
        chk("abort_add",    {31'd0, if2.add_cin, if2.add_a}, 64'd0);
        tick;
        chk("abort_done2",  {60'd0, if2.done}, 64'd0);
        rst = 1'b0;
        if2.op_a[0 +: 32] = 32'd3; if2.op_b[0 +: 32] = 32'd4; if2.op_cin[0] = 1'b0;
        if2.req = 4'b1111;
        tick;
        chk("after_rst_grant", {60'd0, if2.grant}, 64'h1);
        tick;
        tick;
        tick;
        chk("after_rst_wait", {60'd0, if2.done}, 64'd0);
        tick;
        chk("after_rst_done",   {60'd0, if2.done}, 64'h1);
        chk("after_rst_result", {32'd0, if2.result}, 64'd7);
        if2.req = 4'b0000;
        tick;
        chk("after_rst_idle", {59'd0, if2.busy, if2.grant}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/adder_rr_arbiter.md
# adder_rr_arbiter

- Round-robin arbiter and sequencer that shares one registered 32-bit adder (operands a, b, cin → sum, carry) between NREQ requesters.
- Selects one pending request and latches its operands onto the adder inputs.
- Waits the adder's fixed pipeline latency, then captures sum/carry and returns them to the granted requester with a one-cycle done pulse.
- Sits between the requesting datapath blocks and the single shared adder instance; performs no arithmetic itself.

## Interface

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 32, operand/sum width
- LAT, 1, adder latency in clock cycles from add_a/add_b/add_cin valid to add_sum/add_carry valid (1..7)

Ports:
- clock  in  1  single system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  NREQ  request per requester; held high with stable operands until that requester's done pulse
- op_a  in  NREQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH]
- op_b  in  NREQ*WIDTH  operand B; same slicing as op_a
- op_cin  in  NREQ  carry-in per requester
- add_a  out  WIDTH  registered operand A to shared adder
- add_b  out  WIDTH  registered operand B to shared adder
- add_cin  out  1  registered carry-in to shared adder
- add_sum  in  WIDTH  adder sum
- add_carry  in  1  adder carry-out
- grant  out  NREQ  one-hot; high for the requester being served, from issue through the done cycle
- done  out  NREQ  one-hot, one-cycle pulse marking result valid for that requester
- result  out  WIDTH  captured sum; held until the next capture
- result_carry  out  1  captured carry; held with result
- busy  out  1  high whenever state ≠ IDLE

## Operation

Three-state FSM: IDLE, RUN, DONE. Internal state: 3-bit wait counter, served index idx, round-robin pointer ptr.

- **IDLE**: if req ≠ 0, choose the first asserted req scanning ptr, ptr+1, … modulo NREQ.
  - Latch idx.
  - Register that requester's op_a/op_b/op_cin onto add_a/add_b/add_cin.
  - Set grant[idx] and busy; counter = LAT − 1; go to RUN.
  - If req = 0, stay in IDLE; add_* hold their last values.
- **RUN**:
  - If counter ≠ 0: decrement.
  - If counter = 0: result ← add_sum, result_carry ← add_carry, done[idx] ← 1, go to DONE.
- **DONE**:
  - done cleared, grant cleared, busy cleared.
  - ptr ← (idx + 1) mod NREQ; go to IDLE.
  - req is not evaluated in DONE.
- **Arithmetic**: none in this block. result and result_carry are the adder's outputs verbatim; sum wraps modulo 2^WIDTH, with carry = bit WIDTH of a + b + cin.
- **Operand stability**: operands are latched at issue. op_* changes after issue do not affect the result.
- **Dropped request**: if req[idx] drops during RUN, the operation still completes and done[idx] still pulses.
- **Fairness**: the just-served requester has lowest priority on the next arbitration. Requesters held high are served in strict rotation.
- **Reset**:
  - Returns FSM to IDLE; ptr = 0.
  - grant, done, busy, result, result_carry, add_a, add_b, add_cin all = 0.
  - Reset during RUN/DONE aborts the operation; no done pulse is produced.

## Timing

- Request sampled high at edge E0 (IDLE). After E0: grant, busy and add_* are valid.
- Result captured at edge E_LAT; done is high between E_LAT and E_LAT+1.
- After E_LAT+1: state is IDLE, grant = 0, busy = 0.
- Next request can be sampled at E_LAT+2, giving:
  - one operation per LAT + 2 cycles;
  - request-to-done latency LAT cycles after the issue edge.
- Simultaneous requests: exactly one grant per arbitration; the others wait with no loss.
- Request arriving during busy: served in a later IDLE cycle.

## Test plan

Bench models the adder as LAT register stages of {carry, sum} = a + b + cin.

1. **Reset**: reset high 2 cycles with req = 1111 → after the reset edge, all outputs 0; no grant until reset falls.
2. **Single request**: LAT = 1, req0 with a = 500, b = 600, cin = 0.
   - grant = 0001 after E0.
   - done = 0001 after E1, result = 1100, result_carry = 0.
   - busy low after E2.
3. **Rotation**: req = 1111 held, LAT = 1 → grants in order 0, 1, 2, 3, 0, each 3 cycles apart. Requester 1 with a = 1500, b = 11600, cin = 1 → result = 13101.
4. **Wrap-around**:
   - a = FFFFFFFF, b = 1, cin = 0 → result = 0, carry = 1.
   - a = FFFFFFFF, b = FFFFFFFF, cin = 1 → result = FFFFFFFF, carry = 1.
5. **Operand change**: LAT = 4, requester 2 with a = 50000, b = 60020; change op_a to 0 one cycle after grant → result = 110020.
6. **Reset mid-operation**: LAT = 4, reset asserted 2 cycles into RUN → no done pulse, all outputs 0. Subsequent req = 1111 is granted to requester 0 first.
